// File: rtl/mod_exp_if.sv
// Request/response and modulo-table signals of the mod_exp engine.
// slave = engine side, master = requester + table side.
interface mod_exp_if #(
  parameter int N_WIDTH   = 6,
  parameter int NUM_WIDTH = 12,
  parameter int EXP_WIDTH = 6
);
  // Handshake: start is sampled only while busy=0; busy rises on the accepting
  // edge and falls on the edge that raises done for exactly one cycle. result
  // is valid from that edge and holds until the next done. The table has no
  // handshake: lut_rem answers lut_num/lut_n one clock later.
  logic                 start;
  logic [N_WIDTH-1:0]   base;
  logic [EXP_WIDTH-1:0] exp;
  logic [N_WIDTH-1:0]   n;
  logic                 busy;
  logic                 done;
  logic [N_WIDTH-1:0]   result;
  logic [NUM_WIDTH-1:0] lut_num;
  logic [N_WIDTH-1:0]   lut_n;
  logic [N_WIDTH-1:0]   lut_rem;
  logic [3:0]           dbg_state;

  modport slave (
    input  start, base, exp, n, lut_rem,
    output busy, done, result, lut_num, lut_n, dbg_state
  );

  modport master (
    output start, base, exp, n, lut_rem,
    input  busy, done, result, lut_num, lut_n, dbg_state
  );
endinterface

// File: rtl/mod_exp.sv
// Left-to-right square-and-multiply modular exponentiation; every reduction
// is delegated to an external registered num % N lookup table.
module mod_exp #(
  parameter int N_WIDTH   = 6,
  parameter int NUM_WIDTH = 12,
  parameter int EXP_WIDTH = 6
) (
  input  logic       clk,
  input  logic       rst,
  mod_exp_if.slave   bus
);
  localparam int BW = (EXP_WIDTH > 1) ? $clog2(EXP_WIDTH) : 1;

  typedef enum logic [3:0] {
    IDLE, RB_ISS, RB_CAP, SQ_ISS, SQ_CAP, MU_ISS, MU_CAP, FN_ISS, FN_CAP
  } state_t;

  state_t               state_q, state_d;
  logic [N_WIDTH-1:0]   base_q, base_d;
  logic [N_WIDTH-1:0]   n_q, n_d;
  logic [N_WIDTH-1:0]   acc_q, acc_d;
  logic [N_WIDTH-1:0]   result_q, result_d;
  logic [EXP_WIDTH-1:0] exp_q, exp_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [NUM_WIDTH-1:0] acc_x, base_x, num_c;

  assign acc_x  = NUM_WIDTH'(acc_q);
  assign base_x = NUM_WIDTH'(base_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      base_q   <= '0;
      n_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      exp_q    <= '0;
      bit_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      n_q      <= n_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      exp_q    <= exp_d;
      bit_q    <= bit_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    base_d   = base_q;
    n_d      = n_q;
    acc_d    = acc_q;
    result_d = result_q;
    exp_d    = exp_q;
    bit_d    = bit_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    num_c    = '0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          base_d  = bus.base;
          exp_d   = bus.exp;
          n_d     = bus.n;
          acc_d   = N_WIDTH'(1);
          bit_d   = BW'(EXP_WIDTH - 1);
          busy_d  = 1'b1;
          state_d = RB_ISS;
        end
      end
      // The base may be >= n, so it is reduced once before the first multiply.
      RB_ISS: begin
        num_c   = base_x;
        state_d = RB_CAP;
      end
      RB_CAP: begin
        base_d  = bus.lut_rem;
        state_d = SQ_ISS;
      end
      SQ_ISS: begin
        num_c   = acc_x * acc_x;
        state_d = SQ_CAP;
      end
      SQ_CAP: begin
        acc_d   = bus.lut_rem;
        state_d = MU_ISS;
      end
      // Multiply is issued for every bit so timing is data-independent.
      MU_ISS: begin
        num_c   = acc_x * base_x;
        state_d = MU_CAP;
      end
      MU_CAP: begin
        if (exp_q[bit_q]) acc_d = bus.lut_rem;
        if (bit_q == '0) begin
          state_d = FN_ISS;
        end else begin
          bit_d   = bit_q - BW'(1);
          state_d = SQ_ISS;
        end
      end
      // Final reduction makes exp=0 and n<=1 come out right without special cases.
      FN_ISS: begin
        num_c   = acc_x;
        state_d = FN_CAP;
      end
      FN_CAP: begin
        result_d = bus.lut_rem;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.lut_num   = num_c;
  assign bus.lut_n     = n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.dbg_state = state_q;
endmodule
